// File: rtl/minilab0.sv
// minilab0: DE1-SoC self-test that fills two FIFOs with fixed sequences and
// multiply-accumulates them, showing the 24-bit result on HEX5..HEX0.
// Latency: DONE is reached 18 cycles after reset release; the display is
// combinational from registered state.
// Backpressure: none. The FILL/EXEC sequencing obeys the FIFO full/empty flags.
//
// Ports:
//   CLOCK_50            functional clock
//   CLOCK2/3/4_50       unused (pinout only)
//   KEY[0]              rst_n (synchronous, active-low); KEY[3:1] unused
//   SW[0]               display enable; SW[9:1] unused
//   HEX0..HEX5          active-low seven-segment digits, HEX0 = least significant nibble
//   LEDR[1:0]           FSM state (FILL=00, EXEC=01, DONE=10); LEDR[9:2] = 0

// minilab0_fifo: synchronous DEPTH x DATA_WIDTH first-in first-out buffer.
// Latency: rd_dat is registered and valid the cycle after rden.
// Backpressure: a write while full and a read while empty are dropped; rd_dat holds.
module minilab0_fifo #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wren,
  input  logic                  rden,
  input  logic [DATA_WIDTH-1:0] wr_dat,
  output logic [DATA_WIDTH-1:0] rd_dat,
  output logic                  full,
  output logic                  empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST_C  = AW'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           count;
  logic                  do_wr;
  logic                  do_rd;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign do_wr = wren && !full;
  assign do_rd = rden && !empty;

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rd_dat <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= (wr_ptr == LAST_C) ? '0 : wr_ptr + AW'(1);
      end
      if (do_rd) begin
        rd_ptr <= (rd_ptr == LAST_C) ? '0 : rd_ptr + AW'(1);
        rd_dat <= mem[rd_ptr];
      end
      // Simultaneous read and write leave the count unchanged.
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// minilab0: top level, FILL -> EXEC -> DONE sequencer with MAC and display.
// Latency: 8 fill cycles, 1 turnaround, 8 reads plus 1 MAC pipeline cycle.
// Backpressure: writes stop on FIFO full, reads stop on FIFO empty.
module minilab0 #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 24
) (
  input  logic       CLOCK_50,
  input  logic       CLOCK2_50,
  input  logic       CLOCK3_50,
  input  logic       CLOCK4_50,
  input  logic [3:0] KEY,
  input  logic [9:0] SW,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5,
  output logic [9:0] LEDR
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    FILL = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_t;

  logic                    rst_n;
  state_t                  state;
  state_t                  next_state;
  logic [CW-1:0]           fill_cnt;
  logic [CW-1:0]           rd_cnt;
  logic                    mac_vld;
  logic [ACC_WIDTH-1:0]    acc;
  logic                    wren;
  logic                    rden;
  logic [DATA_WIDTH-1:0]   fill_idx;
  logic [DATA_WIDTH-1:0]   wr_dat0;
  logic [DATA_WIDTH-1:0]   wr_dat1;
  logic [DATA_WIDTH-1:0]   rd_dat0;
  logic [DATA_WIDTH-1:0]   rd_dat1;
  logic                    full0;
  logic                    full1;
  logic                    empty0;
  logic                    empty1;
  logic [2*DATA_WIDTH-1:0] prod;
  logic                    show;
  logic                    unused_ok;

  assign rst_n = KEY[0];

  // Inputs present only for the board pinout.
  assign unused_ok = &{1'b0, KEY[3:1], SW[9:1], CLOCK2_50, CLOCK3_50, CLOCK4_50};

  // Operand sequences: FIFO0 gets 5*(i+1), FIFO1 gets 10*(i+1).
  assign fill_idx = DATA_WIDTH'(fill_cnt) + DATA_WIDTH'(1);
  assign wr_dat0  = fill_idx * DATA_WIDTH'(5);
  assign wr_dat1  = fill_idx * DATA_WIDTH'(10);

  assign wren = (state == FILL) && (fill_cnt < DEPTH_C) && !full0 && !full1;
  assign rden = (state == EXEC) && !empty0 && !empty1 && (rd_cnt < DEPTH_C);

  minilab0_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH)) u_fifo0 (
    .clk    (CLOCK_50),
    .rst_n  (rst_n),
    .wren   (wren),
    .rden   (rden),
    .wr_dat (wr_dat0),
    .rd_dat (rd_dat0),
    .full   (full0),
    .empty  (empty0)
  );

  minilab0_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH)) u_fifo1 (
    .clk    (CLOCK_50),
    .rst_n  (rst_n),
    .wren   (wren),
    .rden   (rden),
    .wr_dat (wr_dat1),
    .rd_dat (rd_dat1),
    .full   (full1),
    .empty  (empty1)
  );

  assign prod = (2 * DATA_WIDTH)'(rd_dat0) * (2 * DATA_WIDTH)'(rd_dat1);

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      state    <= FILL;
      fill_cnt <= '0;
      rd_cnt   <= '0;
      mac_vld  <= 1'b0;
      acc      <= '0;
    end else begin
      state <= next_state;
      if (wren) begin
        fill_cnt <= fill_cnt + CW'(1);
      end
      if (rden) begin
        rd_cnt <= rd_cnt + CW'(1);
      end
      // FIFO read data lands one cycle after rden, so the MAC uses a delayed copy.
      mac_vld <= rden;
      if (mac_vld) begin
        acc <= acc + ACC_WIDTH'(prod);
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      FILL: if (full0 && full1) next_state = EXEC;
      // All reads issued and the last product is being accumulated this cycle.
      EXEC: if (mac_vld && (rd_cnt == DEPTH_C)) next_state = DONE;
      DONE: next_state = DONE;
      default: next_state = FILL;
    endcase
  end

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0011000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign show = SW[0] && (state == DONE);

  always_comb begin
    HEX0 = 7'b1111111;
    HEX1 = 7'b1111111;
    HEX2 = 7'b1111111;
    HEX3 = 7'b1111111;
    HEX4 = 7'b1111111;
    HEX5 = 7'b1111111;
    if (show) begin
      HEX0 = seg7(acc[3:0]);
      HEX1 = seg7(acc[7:4]);
      HEX2 = seg7(acc[11:8]);
      HEX3 = seg7(acc[15:12]);
      HEX4 = seg7(acc[19:16]);
      HEX5 = seg7(acc[23:20]);
    end
  end

  assign LEDR = {8'b0, state};
endmodule

// File: tb/tb_minilab0.sv
module tb_minilab0;
  localparam int DEPTH = 8;

  logic       CLOCK_50 = 1'b0;
  logic       clk2 = 1'b0;
  logic       clk3 = 1'b0;
  logic       clk4 = 1'b0;
  logic       key0 = 1'b0;
  logic [2:0] key_hi = 3'b0;
  logic       sw0 = 1'b0;
  logic [8:0] sw_hi = 9'b0;
  logic [3:0] KEY;
  logic [9:0] SW;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic [9:0] LEDR;

  assign KEY = {key_hi, key0};
  assign SW  = {sw_hi, sw0};

  minilab0 dut (
    .CLOCK_50  (CLOCK_50),
    .CLOCK2_50 (clk2),
    .CLOCK3_50 (clk3),
    .CLOCK4_50 (clk4),
    .KEY       (KEY),
    .SW        (SW),
    .HEX0      (HEX0),
    .HEX1      (HEX1),
    .HEX2      (HEX2),
    .HEX3      (HEX3),
    .HEX4      (HEX4),
    .HEX5      (HEX5),
    .LEDR      (LEDR)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int total = 0;
  int bad   = 0;
  bit noise = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: expected result is the plain sum of the operand products, and the
  // phase follows from how many run cycles have elapsed since reset release
  // (8 fill writes + 1 turnaround, then 8 reads + 1 MAC delay).
  logic [23:0] exp_acc;
  logic [6:0]  seg_tbl [16];
  int          since = 0;
  bit          model_ok = 1'b0;

  initial begin
    int s;
    s = 0;
    for (int i = 1; i <= DEPTH; i++) s += (5 * i) * (10 * i);
    exp_acc = 24'(s);
    seg_tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  end

  always @(posedge CLOCK_50) begin
    if (!key0) begin
      since    <= 0;
      model_ok <= 1'b1;
    end else if (model_ok) begin
      since <= since + 1;
    end
  end

  function automatic logic [1:0] exp_state(input int s);
    if (s <= DEPTH) return 2'b00;
    if (s <= 2 * DEPTH + 1) return 2'b01;
    return 2'b10;
  endfunction

  function automatic logic [6:0] get_hex(input int d);
    case (d)
      0: return HEX0;
      1: return HEX1;
      2: return HEX2;
      3: return HEX3;
      4: return HEX4;
      default: return HEX5;
    endcase
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge CLOCK_50) begin
    if (model_ok) begin
      logic [1:0] es;
      logic [6:0] eh;
      es = exp_state(since);
      check("ledr", {22'b0, LEDR}, {22'b0, 8'b0, es});
      for (int d = 0; d < 6; d++) begin
        eh = (sw0 && es == 2'b10) ? seg_tbl[exp_acc[4*d +: 4]] : 7'h7F;
        check($sformatf("hex%0d", d), {25'b0, get_hex(d)}, {25'b0, eh});
      end
    end
  end

  // Unused inputs get scrambled while noise is enabled.
  initial begin
    forever begin
      @(posedge CLOCK_50);
      #3;
      if (noise) begin
        key_hi = 3'($urandom);
        sw_hi  = 9'($urandom);
        clk2   = 1'($urandom);
        clk3   = 1'($urandom);
        clk4   = 1'($urandom);
      end
    end
  end

  task automatic wait_led(input logic [1:0] want, input int budget, input string name);
    int n;
    n = 0;
    while (LEDR[1:0] !== want && n < budget) begin
      @(negedge CLOCK_50);
      n++;
    end
    total++;
    if (LEDR[1:0] !== want) begin
      bad++;
      $display("FAIL %s: ledr=%b required %b within %0d cycles", name, LEDR[1:0], want, budget);
    end
  endtask

  task automatic hold_reset();
    @(posedge CLOCK_50);
    #2 key0 = 1'b0;
    repeat (2) @(posedge CLOCK_50);
    #2 key0 = 1'b1;
    @(negedge CLOCK_50);
    check("state_after_reset", {30'b0, LEDR[1:0]}, 32'h0);
  endtask

  task automatic check_result_literals(input string tag);
    check({tag, "_hex5"}, {25'b0, HEX5}, {25'b0, 7'b1000000});
    check({tag, "_hex4"}, {25'b0, HEX4}, {25'b0, 7'b1000000});
    check({tag, "_hex3"}, {25'b0, HEX3}, {25'b0, 7'b0100100});
    check({tag, "_hex2"}, {25'b0, HEX2}, {25'b0, 7'b1111000});
    check({tag, "_hex1"}, {25'b0, HEX1}, {25'b0, 7'b0100001});
    check({tag, "_hex0"}, {25'b0, HEX0}, {25'b0, 7'b0000000});
  endtask

  initial begin
    // Run 1: display enabled throughout, so FILL/EXEC must stay blank.
    sw0 = 1'b1;
    repeat (2) @(posedge CLOCK_50);
    #2 key0 = 1'b1;
    @(negedge CLOCK_50);
    check("state_after_reset", {30'b0, LEDR[1:0]}, 32'h0);
    wait_led(2'b01, 12, "reach_exec1");
    wait_led(2'b10, 14, "reach_done1");
    @(negedge CLOCK_50);
    check_result_literals("run1");

    // Display disable in DONE.
    @(posedge CLOCK_50);
    #2 sw0 = 1'b0;
    @(negedge CLOCK_50);
    check("blank_hex0", {25'b0, HEX0}, {25'b0, 7'b1111111});
    check("blank_hex5", {25'b0, HEX5}, {25'b0, 7'b1111111});
    #2 sw0 = 1'b1;

    // Reset from DONE, second run must not carry over the accumulator.
    hold_reset();
    wait_led(2'b10, 25, "reach_done2");
    @(negedge CLOCK_50);
    check_result_literals("run2");

    // Reset mid-EXEC with unused inputs scrambled.
    hold_reset();
    noise = 1'b1;
    wait_led(2'b01, 12, "reach_exec3");
    repeat (3) @(posedge CLOCK_50);
    #2 key0 = 1'b0;
    repeat (2) @(posedge CLOCK_50);
    #2 key0 = 1'b1;
    @(negedge CLOCK_50);
    check("state_mid_exec_reset", {30'b0, LEDR[1:0]}, 32'h0);
    wait_led(2'b01, 12, "reach_exec4");
    wait_led(2'b10, 14, "reach_done4");
    @(negedge CLOCK_50);
    check_result_literals("run4");
    repeat (5) @(negedge CLOCK_50);
    check("done_holds", {30'b0, LEDR[1:0]}, 32'h2);
    noise = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
